// File: rtl/axi_wresp_xbar.sv
// AXI write-response (B channel) crossbar: NUM_S slaves to NUM_M masters.
// Each master has its own round-robin arbiter and a registered output slot.
module axi_wresp_xbar #(
    parameter int NUM_S  = 7,
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int MIDX_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_S-1:0]              S_BVALID,
    input  logic [NUM_S*(MIDX_W+ID_W)-1:0] S_BID,
    input  logic [NUM_S*2-1:0]            S_BRESP,
    output logic [NUM_S-1:0]              S_BREADY,
    output logic [NUM_M-1:0]              M_BVALID,
    output logic [NUM_M*ID_W-1:0]         M_BID,
    output logic [NUM_M*2-1:0]            M_BRESP,
    input  logic [NUM_M-1:0]              M_BREADY,
    output logic                          err_badid
);

    localparam int SID_W = MIDX_W + ID_W;
    localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    logic [NUM_S-1:0] req [NUM_M];
    logic [NUM_S-1:0] bad;
    logic [NUM_S-1:0] rdy;
    logic [NUM_M-1:0] win_vld;
    logic [NUM_M-1:0] gnt_vld;
    logic [NUM_M-1:0] free;
    logic [PTR_W-1:0] win_idx [NUM_M];
    logic [PTR_W-1:0] ptr_q   [NUM_M];
    logic [NUM_M-1:0] vld_q;
    logic [ID_W-1:0]  bid_q   [NUM_M];
    logic [1:0]       resp_q  [NUM_M];
    logic             err_q;

    function automatic int midx_of(input logic [NUM_S*SID_W-1:0] bid, input int s);
        return int'(bid[s*SID_W + ID_W +: MIDX_W]);
    endfunction

    // Scanning from the far end means the last hit is the first slave at or after ptr.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_S-1:0] r,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_S - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_S) idx = idx - NUM_S;
            if (r[idx]) res = {1'b1, PTR_W'(idx)};
        end
        return res;
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        bad = '0;
        for (int m = 0; m < NUM_M; m++) req[m] = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (S_BVALID[s]) begin
                if (midx_of(S_BID, s) >= NUM_M) bad[s] = 1'b1;
                for (int m = 0; m < NUM_M; m++)
                    if (midx_of(S_BID, s) == m) req[m][s] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            {win_vld[m], win_idx[m]} = rr_pick(req[m], ptr_q[m]);
            free[m]    = ~vld_q[m] | M_BREADY[m];
            gnt_vld[m] = win_vld[m] & free[m] & ~rst;
        end
    end

    // Ready is combinational so the slave handshake completes in the grant cycle.
    always_comb begin
        rdy = bad;
        for (int m = 0; m < NUM_M; m++)
            if (gnt_vld[m]) rdy[win_idx[m]] = 1'b1;
        S_BREADY = rst ? '0 : rdy;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= 1'b0;
            for (int m = 0; m < NUM_M; m++) begin
                ptr_q[m]  <= '0;
                bid_q[m]  <= '0;
                resp_q[m] <= '0;
            end
        end else begin
            err_q <= |bad;
            for (int m = 0; m < NUM_M; m++) begin
                if (gnt_vld[m]) begin
                    vld_q[m]  <= 1'b1;
                    bid_q[m]  <= S_BID[int'(win_idx[m])*SID_W +: ID_W];
                    resp_q[m] <= S_BRESP[int'(win_idx[m])*2 +: 2];
                    ptr_q[m]  <= (int'(win_idx[m]) == NUM_S - 1) ? '0 : win_idx[m] + 1'b1;
                end else if (M_BREADY[m]) begin
                    vld_q[m] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        M_BID   = '0;
        M_BRESP = '0;
        for (int m = 0; m < NUM_M; m++) begin
            M_BID[m*ID_W +: ID_W] = bid_q[m];
            M_BRESP[m*2 +: 2]     = resp_q[m];
        end
    end

    assign M_BVALID  = vld_q;
    assign err_badid = err_q;

endmodule

// File: doc/axi_wresp_xbar.md
Name: axi_wresp_xbar

Overview:
Parametrised AXI write-response (B channel) crossbar between NUM_S slave ports (last index is the default slave) and NUM_M master ports. Each slave response is routed to the master encoded in the upper bits of its BID. Each master runs its own round-robin arbiter, and each master has a registered output slot, so different masters are served in parallel. Sits in the AXI interconnect beside the AR/R/AW/W channel blocks.

Parameters:
NUM_S, 7, number of slave ports including the default slave at index NUM_S-1
NUM_M, 2, number of master ports
ID_W, 4, master-side BID width (AXI_ID_BITS)
MIDX_W, 4, master-index field width prepended to the ID on the slave side; SID_W = MIDX_W + ID_W

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
S_BVALID  input  NUM_S  per-slave response valid
S_BID  input  NUM_S*SID_W  slave s at [s*SID_W +: SID_W]; master index = bits [SID_W-1:ID_W]
S_BRESP  input  NUM_S*2  slave s at [s*2 +: 2]
S_BREADY  output  NUM_S  per-slave ready
M_BVALID  output  NUM_M  per-master response valid
M_BID  output  NUM_M*ID_W  master m at [m*ID_W +: ID_W]
M_BRESP  output  NUM_M*2  master m at [m*2 +: 2]
M_BREADY  input  NUM_M  per-master ready
err_badid  output  1  one-cycle pulse when a response with master index >= NUM_M is discarded

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. Reset values: M_BVALID=0, M_BID=0, M_BRESP=0, err_badid=0, all rr pointers=0. S_BREADY is combinational and is 0 while rst=1.
- Request: req[m][s] = S_BVALID[s] & (midx(s)==m). A slave requests exactly one master, so S_BREADY has no multi-driver conflict.
- Slot free for master m: free[m] = ~M_BVALID[m] | M_BREADY[m].
- Arbitration per master: round-robin over slaves, starting at ptr[m] and searching upward with wrap at NUM_S. The winner g is granted only when free[m]=1. Grant is combinational: S_BREADY[g]=1 in the same cycle, so the slave handshake completes that cycle.
- On grant: next cycle M_BVALID[m]=1, M_BID[m]=S_BID[g][ID_W-1:0], M_BRESP[m]=S_BRESP[g], and ptr[m] <= (g+1) mod NUM_S. The slave-to-master latency is exactly 1 cycle.
- Output slot: holds stable while M_BVALID & ~M_BREADY. When M_BREADY=1 and a new grant occurs in the same cycle, the slot reloads back-to-back with no bubble. With M_BREADY=1 and no grant, M_BVALID clears next cycle.
- Throughput: 1 response per cycle per master. Different masters complete in the same cycle independently.
- Bad ID (midx >= NUM_M): S_BREADY[s]=1 immediately, the response is dropped, and err_badid=1 for that one cycle. The pulse also fires when several bad-ID slaves are accepted in the same cycle.
- The pointer does not move when there is no grant. A slave that drops BVALID before its grant is simply not requested; this is illegal per AXI, and no recovery is required.
- Reset mid-transfer: all output slots are flushed and pointers return to 0, with no residual BVALID.
- BRESP is passed through unmodified, including DECERR from the default slave.

Test Plan:
- Reset, then S0 BVALID with BID={4'd1,4'h3}, BRESP=0, M_BREADY[1]=1 -> S_BREADY[0]=1 in the same cycle; next cycle M_BVALID[1]=1, M_BID[1]=4'h3; M_BVALID[0]=0.
- S1, S2, S3 all targeting master 0 and held valid, M_BREADY[0]=1, ptr=0 -> grant order S1, S2, S3 on consecutive cycles; M_BVALID[0] stays high for 3 cycles with no bubble.
- Backpressure: master 0 slot full, M_BREADY[0]=0 for 4 cycles while S2 is valid -> S_BREADY[2]=0 and M_BID[0]/M_BRESP[0] stable; after M_BREADY rises, S2 is granted in that cycle and appears the next cycle.
- Parallel masters: S0 to master 0 and default slave (S6, BRESP=2'b11) to master 1 in the same cycle -> both S_BREADY high; next cycle M_BVALID=2'b11 and M_BRESP[1]=2'b11.
- Fairness: S0 and S4 both to master 0 and held valid continuously -> grants alternate S0, S4, S0, S4.
- Bad ID: S5 with midx=4'd3 (NUM_M=2) -> S_BREADY[5]=1 and err_badid=1 for one cycle; no M_BVALID asserted. Also assert rst while M_BVALID[0]=1 -> M_BVALID=0 the next cycle.
